hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline hazard detector for the 5-stage core. It detects load-use, flag-to-branch and register-to-branch-register hazards. It adds a whole-pipeline freeze for memory wait states, IF/ID flush on taken branches (including flushes deferred across a freeze), a saturating stall-cycle performance counter and a sticky stall watchdog. It sits in the ID stage beside the control unit and drives PC, IF/ID, ID/EX-bubble and downstream pipeline-register enables.

Parameters:
REG_AW, 4, register-address width
OPC_W, 4, opcode width
FLAG_W, 3, flag-enable vector width (Z,V,N)
OP_B, 4'b1100, conditional branch opcode
OP_BR, 4'b1101, branch-register opcode
COND_ALWAYS, 3'b111, unconditional condition code
IGNORE_R0, 1, 1: register hazards against R0 never stall
CNT_W, 16, stall-cycle counter width
MAX_STALL, 8, consecutive hazard-stall cycles before watchdog trips (>=1)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
idex_memread  in  1  ID/EX instruction is a load
idex_regwrite  in  1  ID/EX instruction writes rd
idex_flag_en  in  FLAG_W  flags the ID/EX instruction updates
idex_rd  in  REG_AW  ID/EX destination
exmem_memread  in  1  EX/MEM instruction is a load
exmem_regwrite  in  1  EX/MEM instruction writes rd
exmem_rd  in  REG_AW  EX/MEM destination
ifid_opcode  in  OPC_W  decoding opcode
ifid_rs  in  REG_AW  source 1
ifid_rt  in  REG_AW  source 2
ifid_cond  in  3  branch condition
branch_taken  in  1  ID branch resolved taken
imem_busy  in  1  instruction memory not ready
dmem_busy  in  1  data memory not ready
stall_cnt_clr  in  1  synchronous clear of stall counter
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID load NOP
control_mux  out  1  1=pass ID controls, 0=inject bubble into ID/EX
pipe_write_en  out  1  ID/EX, EX/MEM, MEM/WB enable
stall_cnt  out  CNT_W  saturating count of non-RUN cycles
hazard_err  out  1  sticky watchdog flag

Behaviour:
- Hazard terms (combinational). match(a,b) = (a==b) & !(IGNORE_R0 & a==0).
- LU = idex_memread & (match(idex_rd,ifid_rs) | match(idex_rd,ifid_rt)).
- FB = (opcode==OP_B | opcode==OP_BR) & idex_flag_en!=0 & ifid_cond!=COND_ALWAYS. The condition gate applies to flag hazards only.
- RB = opcode==OP_BR & ((idex_regwrite & match(idex_rd,ifid_rs)) | (exmem_memread & exmem_regwrite & match(exmem_rd,ifid_rs))).
- haz = LU|FB|RB. frz = imem_busy|dmem_busy.
- FSM states RUN, HAZ, FREEZE. State is registered; the next state is computed from current inputs:
  - frz goes to FREEZE.
  - else haz goes to HAZ.
  - else RUN.
  - Priority is freeze > hazard > flush.
- Outputs are combinational from the current inputs, so the response takes effect in the same cycle:
  - frz: pc_write_en=0, ifid_write_en=0, pipe_write_en=0, control_mux=1, ifid_flush=0.
  - haz & !frz: pc_write_en=0, ifid_write_en=0, control_mux=0, pipe_write_en=1, ifid_flush=0.
  - otherwise: all enables 1, control_mux=1.
- Flush:
  - branch_taken is ignored while haz=1, because the branch is not yet resolved.
  - branch_taken & !haz & !frz: ifid_flush=1 for that cycle.
  - branch_taken & frz: set registered flush_pend. ifid_flush is then asserted in the first cycle with !frz and flush_pend is cleared. A new branch_taken in that same cycle merges with the pending one and produces a single pulse.
- stall_cnt:
  - Increments each clock edge where the current cycle has frz|haz, saturating at 2^CNT_W-1.
  - stall_cnt_clr wins over increment and sets the counter to 0.
- Watchdog:
  - Counter hz_run counts consecutive haz & !frz cycles and resets on any other cycle.
  - When hz_run reaches MAX_STALL, hazard_err sets and stays set until reset.
  - A freeze cycle resets hz_run.
- Reset (rst_n low, asynchronous):
  - State=RUN, flush_pend=0, stall_cnt=0, hz_run=0, hazard_err=0.
  - While rst_n is low, outputs are forced to: pc_write_en=0, ifid_write_en=0, pipe_write_en=0, control_mux=0, ifid_flush=1.
  - Reset asserted mid-freeze discards any pending flush.

Decomposition:
- Shared package hazard_pkg holds:
  - opcode constants OP_B and OP_BR;
  - COND_ALWAYS;
  - the FSM state enum (RUN, HAZ, FREEZE).
- One sub-module, hazard_detect_comb, computes LU/FB/RB/haz from the pipeline-register fields.
- The top module keeps the FSM, flush_pend, the counters and output muxing.

Test Plan:
- Load-use: idex_memread=1, idex_rd=3, ifid_rs=3, opcode ADD -> pc_write_en=0, ifid_write_en=0, control_mux=0 for 1 cycle; stall_cnt=1.
- Flag-branch gating: opcode OP_B, idex_flag_en=3'b001, cond=3'b000 -> stall. Same with cond=3'b111 -> no stall.
- R0 exemption: load with idex_rd=0, ifid_rs=0, IGNORE_R0=1 -> no stall. With IGNORE_R0=0 -> stall.
- Branch taken during freeze: dmem_busy=1 for 3 cycles with branch_taken pulsed in cycle 1 -> all enables 0 for 3 cycles; ifid_flush=1 exactly in cycle 4; stall_cnt=3.
- Watchdog: hold LU for 8 cycles (MAX_STALL=8) -> hazard_err=1 after the 8th edge and stays 1 after LU clears. Holding LU for 7 cycles, then 1 freeze cycle, then 7 more -> hazard_err=0.
- Async reset mid-stall, plus saturation and clear:
  - Drop rst_n between clock edges while in HAZ -> outputs immediately pc_write_en=0, ifid_flush=1; stall_cnt=0.
  - Force frz continuously with CNT_W=4 -> stall_cnt sticks at 15.
  - Pulse stall_cnt_clr together with frz -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and FSM state type for the ID-stage hazard control unit.
package hazard_pkg;

  localparam logic [3:0] OP_B        = 4'b1100;
  localparam logic [3:0] OP_BR       = 4'b1101;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZ    = 2'd1,
    FREEZE = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect_comb.sv
// Combinational hazard terms: load-use, flag-to-branch and register-to-branch-register.
module hazard_detect_comb #(
  parameter int               REG_AW      = 4,
  parameter int               OPC_W       = 4,
  parameter int               FLAG_W      = 3,
  parameter logic [OPC_W-1:0] OP_B        = hazard_pkg::OP_B,
  parameter logic [OPC_W-1:0] OP_BR       = hazard_pkg::OP_BR,
  parameter logic [2:0]       COND_ALWAYS = hazard_pkg::COND_ALWAYS,
  parameter int               IGNORE_R0   = 1
) (
  input  logic              idex_memread_i,
  input  logic              idex_regwrite_i,
  input  logic [FLAG_W-1:0] idex_flag_en_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              exmem_memread_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [OPC_W-1:0]  ifid_opcode_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic [2:0]        ifid_cond_i,
  output logic              haz_o
);

  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !((IGNORE_R0 != 0) && (a == '0));
  endfunction

  logic is_b, is_br;
  logic lu, fb, rb;

  assign is_b  = (ifid_opcode_i == OP_B);
  assign is_br = (ifid_opcode_i == OP_BR);

  assign lu = idex_memread_i &
              (reg_match(idex_rd_i, ifid_rs_i) | reg_match(idex_rd_i, ifid_rt_i));

  // Unconditional branches do not read flags, so only they escape the flag hazard.
  assign fb = (is_b | is_br) & (idex_flag_en_i != '0) & (ifid_cond_i != COND_ALWAYS);

  assign rb = is_br &
              ((idex_regwrite_i & reg_match(idex_rd_i, ifid_rs_i)) |
               (exmem_memread_i & exmem_regwrite_i & reg_match(exmem_rd_i, ifid_rs_i)));

  assign haz_o = lu | fb | rb;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard/freeze controller: pipeline enables, branch flush (incl. deferred),
// saturating stall counter and sticky stall watchdog.
module hazard_ctrl_unit #(
  parameter int               REG_AW      = 4,
  parameter int               OPC_W       = 4,
  parameter int               FLAG_W      = 3,
  parameter logic [OPC_W-1:0] OP_B        = hazard_pkg::OP_B,
  parameter logic [OPC_W-1:0] OP_BR       = hazard_pkg::OP_BR,
  parameter logic [2:0]       COND_ALWAYS = hazard_pkg::COND_ALWAYS,
  parameter int               IGNORE_R0   = 1,
  parameter int               CNT_W       = 16,
  parameter int               MAX_STALL   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic [FLAG_W-1:0] idex_flag_en,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exmem_memread,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [OPC_W-1:0]  ifid_opcode,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic [2:0]        ifid_cond,
  input  logic              branch_taken,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  input  logic              stall_cnt_clr,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              control_mux,
  output logic              pipe_write_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              hazard_err
);
  import hazard_pkg::*;

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic haz, frz;
  state_e state_q, state_d;
  logic flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] hz_run_q, hz_run_d;
  logic err_q, err_d;

  hazard_detect_comb #(
    .REG_AW(REG_AW), .OPC_W(OPC_W), .FLAG_W(FLAG_W),
    .OP_B(OP_B), .OP_BR(OP_BR), .COND_ALWAYS(COND_ALWAYS), .IGNORE_R0(IGNORE_R0)
  ) u_detect (
    .idex_memread_i  (idex_memread),
    .idex_regwrite_i (idex_regwrite),
    .idex_flag_en_i  (idex_flag_en),
    .idex_rd_i       (idex_rd),
    .exmem_memread_i (exmem_memread),
    .exmem_regwrite_i(exmem_regwrite),
    .exmem_rd_i      (exmem_rd),
    .ifid_opcode_i   (ifid_opcode),
    .ifid_rs_i       (ifid_rs),
    .ifid_rt_i       (ifid_rt),
    .ifid_cond_i     (ifid_cond),
    .haz_o           (haz)
  );

  assign frz = imem_busy | dmem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      hz_run_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
      hz_run_q     <= hz_run_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = RUN;
    flush_pend_d = flush_pend_q;
    cnt_d        = cnt_q;
    hz_run_d     = '0;

    if (frz)      state_d = FREEZE;
    else if (haz) state_d = HAZ;

    // An unresolved branch (haz) cannot request a flush; a pending one waits out hazards too.
    if (frz)       flush_pend_d = flush_pend_q | (branch_taken & ~haz);
    else if (!haz) flush_pend_d = 1'b0;

    if (stall_cnt_clr)                      cnt_d = '0;
    else if ((frz | haz) && (cnt_q != '1))  cnt_d = cnt_q + CNT_W'(1);

    // state_q == HAZ means the previous cycle was also a pure hazard stall.
    if (haz && !frz) begin
      if (state_q != HAZ)                             hz_run_d = RUN_W'(1);
      else if (hz_run_q != RUN_W'(MAX_STALL))         hz_run_d = hz_run_q + RUN_W'(1);
      else                                            hz_run_d = hz_run_q;
    end
    err_d = err_q | (hz_run_d == RUN_W'(MAX_STALL));
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    pipe_write_en = 1'b1;
    control_mux   = 1'b1;
    ifid_flush    = 1'b0;
    if (!rst_n) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      pipe_write_en = 1'b0;
      control_mux   = 1'b0;
      ifid_flush    = 1'b1;
    end else if (frz) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      pipe_write_en = 1'b0;
    end else if (haz) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      control_mux   = 1'b0;
    end else begin
      ifid_flush = branch_taken | flush_pend_q;
    end
  end

  assign stall_cnt  = cnt_q;
  assign hazard_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised + directed bench for hazard_ctrl_unit against an in-bench behavioural model;
// two instances: defaults, and IGNORE_R0=0 with a 4-bit stall counter.
module tb_hazard_ctrl_unit;
  localparam logic [3:0] OPB  = 4'b1100;
  localparam logic [3:0] OPBR = 4'b1101;
  localparam int         MAXS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       idex_memread, idex_regwrite, exmem_memread, exmem_regwrite;
  logic [2:0] idex_flag_en, ifid_cond;
  logic [3:0] idex_rd, exmem_rd, ifid_opcode, ifid_rs, ifid_rt;
  logic       branch_taken, imem_busy, dmem_busy, stall_cnt_clr;

  logic pc_we [2];
  logic ifid_we [2];
  logic flush [2];
  logic cmux [2];
  logic pipe_we [2];
  logic err [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut0 (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_flag_en(idex_flag_en),
    .idex_rd(idex_rd), .exmem_memread(exmem_memread), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_cond(ifid_cond), .branch_taken(branch_taken), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .stall_cnt_clr(stall_cnt_clr),
    .pc_write_en(pc_we[0]), .ifid_write_en(ifid_we[0]), .ifid_flush(flush[0]),
    .control_mux(cmux[0]), .pipe_write_en(pipe_we[0]), .stall_cnt(cnt0), .hazard_err(err[0])
  );

  hazard_ctrl_unit #(.IGNORE_R0(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_flag_en(idex_flag_en),
    .idex_rd(idex_rd), .exmem_memread(exmem_memread), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_cond(ifid_cond), .branch_taken(branch_taken), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .stall_cnt_clr(stall_cnt_clr),
    .pc_write_en(pc_we[1]), .ifid_write_en(ifid_we[1]), .ifid_flush(flush[1]),
    .control_mux(cmux[1]), .pipe_write_en(pipe_we[1]), .stall_cnt(cnt1), .hazard_err(err[1])
  );

  // ---------------- behavioural model ----------------
  int m_cnt [2];
  int m_run [2];
  bit m_err [2];
  bit m_pend [2];
  int cnt_max [2] = '{65535, 15};
  bit ign_r0 [2]  = '{1'b1, 1'b0};

  function automatic bit same_reg(input logic [3:0] a, input logic [3:0] b, input bit ig);
    return (a == b) && !(ig && a == 4'd0);
  endfunction

  function automatic bit haz_f(input int k);
    bit lu, fb, rb;
    lu = idex_memread && (same_reg(idex_rd, ifid_rs, ign_r0[k]) || same_reg(idex_rd, ifid_rt, ign_r0[k]));
    fb = (ifid_opcode == OPB || ifid_opcode == OPBR) && idex_flag_en != 3'd0 && ifid_cond != 3'b111;
    rb = ifid_opcode == OPBR &&
         ((idex_regwrite && same_reg(idex_rd, ifid_rs, ign_r0[k])) ||
          (exmem_memread && exmem_regwrite && same_reg(exmem_rd, ifid_rs, ign_r0[k])));
    return lu || fb || rb;
  endfunction

  function automatic bit frz_f();
    return imem_busy || dmem_busy;
  endfunction

  function automatic int next_cnt(input int k);
    if (stall_cnt_clr) return 0;
    if (frz_f() || haz_f(k)) return (m_cnt[k] + 1 > cnt_max[k]) ? cnt_max[k] : m_cnt[k] + 1;
    return m_cnt[k];
  endfunction

  function automatic bit next_pend(input int k);
    if (frz_f()) return m_pend[k] || (branch_taken && !haz_f(k));
    if (haz_f(k)) return m_pend[k];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] <= 0; m_run[k] <= 0; m_err[k] <= 1'b0; m_pend[k] <= 1'b0;
      end else begin
        m_cnt[k]  <= next_cnt(k);
        m_run[k]  <= (haz_f(k) && !frz_f()) ? m_run[k] + 1 : 0;
        m_err[k]  <= m_err[k] || (haz_f(k) && !frz_f() && m_run[k] + 1 >= MAXS);
        m_pend[k] <= next_pend(k);
      end
    end
  end

  // {pc_write_en, ifid_write_en, pipe_write_en, control_mux, ifid_flush}
  function automatic logic [4:0] exp_ctl(input int k);
    if (!rst_n)    return 5'b00001;
    if (frz_f())   return 5'b00010;
    if (haz_f(k))  return 5'b00100;
    return {4'b1111, branch_taken || m_pend[k]};
  endfunction

  function automatic logic [4:0] act_ctl(input int k);
    return {pc_we[k], ifid_we[k], pipe_we[k], cmux[k], flush[k]};
  endfunction

  function automatic logic [31:0] act_cnt(input int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("ctl{pc,ifid,pipe,cmux,flush}", k, 32'(act_ctl(k)), 32'(exp_ctl(k)));
      chk("stall_cnt", k, act_cnt(k), 32'(m_cnt[k]));
      chk("hazard_err", k, 32'(err[k]), 32'(m_err[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    idex_memread = 0; idex_regwrite = 0; idex_flag_en = 0; idex_rd = 0;
    exmem_memread = 0; exmem_regwrite = 0; exmem_rd = 0;
    ifid_opcode = 0; ifid_rs = 0; ifid_rt = 0; ifid_cond = 0;
    branch_taken = 0; imem_busy = 0; dmem_busy = 0; stall_cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idle();
    idex_memread = 1; idex_rd = 4'd3; ifid_rs = 4'd3;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) step();
    chk("reset_ctl", 0, 32'(act_ctl(0)), 32'(5'b00001));
    chk("reset_cnt", 0, act_cnt(0), 0);
    rst_n = 1;
    #2 chk("idle_ctl", 0, 32'(act_ctl(0)), 32'(5'b11110));
    step();
    $display("txn reset/idle");

    load_use();
    #2 chk("lu_ctl", 0, 32'(act_ctl(0)), 32'(5'b00100));
    step(); idle();
    chk("lu_cnt", 0, act_cnt(0), 1);
    $display("txn load-use");

    ifid_opcode = OPB; idex_flag_en = 3'b001; ifid_cond = 3'b000;
    #2 chk("fb_stall", 0, 32'(act_ctl(0)), 32'(5'b00100));
    step();
    ifid_cond = 3'b111;
    #2 chk("fb_always", 0, 32'(act_ctl(0)), 32'(5'b11110));
    step(); idle();
    $display("txn flag-branch gating");

    idex_memread = 1; idex_rd = 0; ifid_rs = 0;
    #2 chk("r0_ignored", 0, 32'(act_ctl(0)), 32'(5'b11110));
    chk("r0_stalls", 1, 32'(act_ctl(1)), 32'(5'b00100));
    step(); idle();
    $display("txn R0 exemption");

    stall_cnt_clr = 1; step(); idle();
    chk("clr_cnt", 0, act_cnt(0), 0);
    chk("clr_cnt", 1, act_cnt(1), 0);
    dmem_busy = 1; branch_taken = 1;
    #2 chk("frz_ctl", 0, 32'(act_ctl(0)), 32'(5'b00010));
    step(); branch_taken = 0;
    step(); step(); dmem_busy = 0;
    #2 chk("deferred_flush", 0, 32'(act_ctl(0)), 32'(5'b11111));
    chk("frz_cnt", 0, act_cnt(0), 3);
    step();
    #2 chk("flush_once", 0, 32'(act_ctl(0)), 32'(5'b11110));
    $display("txn branch taken during freeze");

    load_use(); repeat (7) step();
    dmem_busy = 1; step(); dmem_busy = 0;
    repeat (7) step(); idle();
    chk("wd_broken_run", 0, 32'(err[0]), 0);
    step();
    load_use(); repeat (7) step();
    chk("wd_7", 0, 32'(err[0]), 0);
    step();
    chk("wd_8", 0, 32'(err[0]), 1);
    idle(); step();
    chk("wd_sticky", 0, 32'(err[0]), 1);
    $display("txn watchdog");

    load_use(); step();
    #2 rst_n = 0;
    #1 chk("async_rst_ctl", 0, 32'(act_ctl(0)), 32'(5'b00001));
    chk("async_rst_cnt", 0, act_cnt(0), 0);
    chk("async_rst_err", 0, 32'(err[0]), 0);
    step(); idle(); rst_n = 1; step();
    $display("txn async reset mid-stall");

    dmem_busy = 1; repeat (20) step();
    chk("sat_cnt", 1, act_cnt(1), 15);
    chk("nosat_cnt", 0, act_cnt(0), 20);
    stall_cnt_clr = 1; step(); stall_cnt_clr = 0;
    chk("clr_wins", 0, act_cnt(0), 0);
    chk("clr_wins", 1, act_cnt(1), 0);
    step(); idle();
    chk("cnt_after_clr", 1, act_cnt(1), 1);
    $display("txn saturation and clear");

    for (int blk = 0; blk < 30; blk++) begin
      for (int c = 0; c < 100; c++) begin
        idex_memread   = ($urandom_range(0, 2) == 0);
        idex_regwrite  = 1'($urandom_range(0, 1));
        idex_flag_en   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        idex_rd        = 4'($urandom_range(0, 3));
        exmem_memread  = 1'($urandom_range(0, 1));
        exmem_regwrite = 1'($urandom_range(0, 1));
        exmem_rd       = 4'($urandom_range(0, 3));
        ifid_rs        = 4'($urandom_range(0, 3));
        ifid_rt        = 4'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       ifid_opcode = OPB;
          1:       ifid_opcode = OPBR;
          default: ifid_opcode = 4'($urandom_range(0, 15));
        endcase
        ifid_cond      = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
        branch_taken   = ($urandom_range(0, 3) == 0);
        imem_busy      = ($urandom_range(0, 9) == 0);
        dmem_busy      = ($urandom_range(0, 9) == 0);
        stall_cnt_clr  = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 0; step(); rst_n = 1;
        end else begin
          step();
        end
      end
      $display("txn random block %0d", blk);
    end
    idle(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
